data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Byte-addressable RV32 data memory for the single-cycle/multicycle core, with a
//  valid/ready request port, configurable wait states and byte/half/word
//  loads and stores selected by funct3. Load results are sign- or zero-extended.
//  Misaligned and illegal accesses are flagged, not executed.
//  A sequential clear FSM zeroes the array after reset. Sits between the core LSU and the array.
// PARAMETERS
//  ADDR_W          10  byte-address width; depth = 2**(ADDR_W-2) 32-bit words
//  WAIT_CYCLES      1  extra cycles between accept and response (0..15)
//  CLEAR_ON_RESET   1  1: sweep-zero array after reset; 0: contents undefined, skip INIT
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       reset, asynchronous, active-low
//  req_valid   in   1       request present
//  req_ready   out  1       block accepts request this cycle
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data; low bytes used for SB/SH
//  rsp_valid   out  1       one-cycle response strobe, no backpressure
//  rsp_rdata   out  32      extended load data; 0 for stores and errors
//  rsp_err     out  1       misaligned or illegal funct3, valid with rsp_valid
//  busy        out  1       high while INIT sweep runs
// BEHAVIOUR
//  - Reset (async, rst=0): state=INIT (IDLE if CLEAR_ON_RESET=0), clr_cnt=0, wait_cnt=0,
//    req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=CLEAR_ON_RESET. Array not reset async.
//  - FSM INIT->IDLE->(WAIT)->RESP->IDLE.
//  - INIT: write 0 to word clr_cnt each cycle, increment; after word depth-1 go IDLE.
//    busy=1 throughout, req_ready=0. Sweep takes exactly 2**(ADDR_W-2) cycles.
//  - IDLE: req_ready=1. Accept on req_valid&req_ready: latch we/funct3/addr/wdata.
//    Go to WAIT with wait_cnt=WAIT_CYCLES-1, or to RESP directly if WAIT_CYCLES=0.
//  - WAIT: decrement; at wait_cnt==0 go RESP. Array access happens on the edge entering RESP.
//    This is the accept edge itself when WAIT_CYCLES=0. Latency accept-edge->rsp_valid = WAIT_CYCLES+1.
//  - RESP: rsp_valid=1 exactly one cycle, req_ready=0, then IDLE.
//    Max throughput is one request per WAIT_CYCLES+2 cycles.
//  - Legal: loads 000,001,010,100,101; stores 000,001,010. Others -> rsp_err=1, no access.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> rsp_err=1, rsp_rdata=0, no write.
//  - Store lanes: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0..1}
//    with wdata[15:0]; SW writes all four lanes. Untouched lanes keep their value.
//  - Load: word = array[addr>>2]. LB/LBU pick byte addr[1:0]; LH/LHU pick half addr[1].
//    LB/LH sign-extend, LBU/LHU zero-extend. rsp_rdata is registered.
//  - Word index uses addr[ADDR_W-1:2]; addresses wrap naturally, no out-of-range case.
//  - req_* ignored outside IDLE. rsp_rdata/rsp_err hold last value while rsp_valid=0.
//  - Reset mid-operation: pending request dropped, no write, no response; INIT restarts at word 0.
// STRUCTURE
//  - Package dmem_pkg: funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU).
//    Also typedef enum state_t {INIT,IDLE,WAIT,RESP}, and functions is_misaligned(),
//    is_legal(), load_extract(word,addr_lo,funct3) and store_be(addr_lo,funct3)->[3:0].
//  - Sub-module dmem_array: word array, 4 byte write-enables, sync write, comb read.
//    Parameterised by depth. INIT drives it through a write-port mux.
//  - Top holds FSM, counters, request latch and response registers.
// TESTING
//  1 Write pattern, pulse rst low, keep req_valid=1 -> busy=1 for 256 cycles (ADDR_W=10),
//    req_ready=0 throughout; then LW 0x010 -> 0x00000000, err=0.
//  2 SW 0x040 0xDEADBEEF; LW 0x040 -> 0xDEADBEEF; LB 0x043 -> 0xFFFFFFDE;
//    LBU 0x043 -> 0x000000DE; LH 0x042 -> 0xFFFFDEAD; LHU 0x040 -> 0x0000BEEF.
//  3 After test 2: SB 0x041 wdata 0xFFFFFF12 -> LW 0x040 -> 0xDEAD12EF;
//    SH 0x042 0x00007654 -> LW 0x040 -> 0x765412EF.
//  4 LW 0x042 -> err=1, rdata=0; SH 0x045 -> err=1, LW 0x044 unchanged;
//    funct3=011 load -> err=1.
//  5 WAIT_CYCLES=0 and 3: rsp_valid exactly 1 and 4 cycles after accept edge, high one cycle;
//    req_ready=0 until back in IDLE.
//  6 SW 0x080 0x12345678 with WAIT_CYCLES=3, assert rst during WAIT -> no rsp_valid;
//    after INIT, LW 0x080 -> 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data memory controller.
//   - funct3 encodings for the load/store widths
//   - controller state type
//   - helpers: access legality, misalignment, load lane extraction/extension,
//     store byte enables and store data lane replication
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   // Unsigned variants only exist for loads.
   function automatic logic is_legal(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !we;
         default:          return 1'b0;
      endcase
   endfunction

   // funct3[1:0] carries the access size for both signed and unsigned forms.
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] f3);
      case (f3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  addr_lo,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_W:    return word;
         F3_BU:   return {24'd0, b};
         F3_HU:   return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] addr_lo, input logic [2:0] f3);
      case (f3)
         F3_B:    return 4'b0001 << addr_lo;
         F3_H:    return addr_lo[1] ? 4'b1100 : 4'b0011;
         F3_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate the low bytes so whichever lanes are enabled see the right data.
   function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [2:0] f3);
      case (f3)
         F3_B:    return {4{wdata[7:0]}};
         F3_H:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the core LSU (master) and the data memory
// controller (slave).
//   req_valid/req_ready handshake, req_we/req_funct3/req_addr/req_wdata payload
//   rsp_valid strobe with rsp_rdata/rsp_err, busy while the clear sweep runs
interface data_memory_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with four byte write enables.
//   clk      in   write clock
//   i_be     in   byte write enables (lane 0 = bits 7:0)
//   i_waddr  in   write word index
//   i_wdata  in   write data
//   i_raddr  in   read word index
//   o_rdata  out  combinational read data
// No reset: contents are only defined after the controller's clear sweep.
module dmem_array #(
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32 data memory controller: valid/ready request port, programmable wait
// states, byte/half/word loads and stores, optional zeroing sweep after reset.
//   clk     in   clock
//   rst     in   asynchronous active-low reset
//   io_bus  slave side of data_memory_ctrl_if (request, response, busy)
//
// state | meaning
// INIT  | clear sweep, one word per cycle, busy=1
// IDLE  | ready for a request
// WAIT  | counting wait states before the array access
// RESP  | one-cycle response strobe
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int WAIT_CYCLES    = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic               clk,
   input  logic               rst,
   data_memory_ctrl_if.slave  io_bus
);

   localparam int WA    = ADDR_W - 2;
   localparam int DEPTH = 2 ** WA;

   state_t            r_state, w_state_nxt;
   logic [WA-1:0]     r_clr_cnt;
   logic [3:0]        r_wait_cnt;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_ready;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [31:0]       r_rsp_rdata;

   logic              w_accept;
   logic              w_do_access;
   logic              w_acc_we;
   logic [2:0]        w_acc_f3;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [31:0]       w_acc_wdata;
   logic              w_acc_ok;
   logic [3:0]        w_mem_be;
   logic [WA-1:0]     w_mem_waddr;
   logic [31:0]       w_mem_wdata;
   logic [31:0]       w_mem_rdata;

   // r_ready is only ever set on entry to IDLE, so it doubles as the IDLE flag.
   assign w_accept = io_bus.req_valid & r_ready;

   // With no wait states the access shares the accept edge, so it must use
   // the live request rather than the latched copy.
   assign w_acc_we    = (WAIT_CYCLES == 0) ? io_bus.req_we     : r_we;
   assign w_acc_f3    = (WAIT_CYCLES == 0) ? io_bus.req_funct3 : r_f3;
   assign w_acc_addr  = (WAIT_CYCLES == 0) ? io_bus.req_addr   : r_addr;
   assign w_acc_wdata = (WAIT_CYCLES == 0) ? io_bus.req_wdata  : r_wdata;
   assign w_acc_ok    = is_legal(w_acc_we, w_acc_f3) && !is_misaligned(w_acc_addr[1:0], w_acc_f3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_do_access = 1'b0;
      w_mem_be    = 4'b0000;
      w_mem_waddr = w_acc_addr[ADDR_W-1:2];
      w_mem_wdata = store_data(w_acc_wdata, w_acc_f3);
      case (r_state)
         INIT: begin
            w_mem_be    = 4'b1111;
            w_mem_waddr = r_clr_cnt;
            w_mem_wdata = 32'd0;
            if (&r_clr_cnt) w_state_nxt = IDLE;
         end
         IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = RESP;
                  w_do_access = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_wait_cnt == 4'd0) begin
               w_state_nxt = RESP;
               w_do_access = 1'b1;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (w_do_access && w_acc_we && w_acc_ok) w_mem_be = store_be(w_acc_addr[1:0], w_acc_f3);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clr_cnt   <= '0;
         r_wait_cnt  <= 4'd0;
         r_we        <= 1'b0;
         r_f3        <= 3'd0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 32'd0;
      end else begin
         r_ready     <= (w_state_nxt == IDLE);
         r_rsp_valid <= w_do_access;
         if (r_state == INIT) r_clr_cnt <= r_clr_cnt + WA'(1);
         if (w_accept) begin
            r_we       <= io_bus.req_we;
            r_f3       <= io_bus.req_funct3;
            r_addr     <= io_bus.req_addr;
            r_wdata    <= io_bus.req_wdata;
            r_wait_cnt <= 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
         end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end
         if (w_do_access) begin
            r_rsp_err   <= !w_acc_ok;
            r_rsp_rdata <= (w_acc_ok && !w_acc_we) ?
                           load_extract(w_mem_rdata, w_acc_addr[1:0], w_acc_f3) : 32'd0;
         end
      end
   end

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .i_be    (w_mem_be),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_raddr (w_acc_addr[ADDR_W-1:2]),
      .o_rdata (w_mem_rdata)
   );

   assign io_bus.req_ready = r_ready;
   assign io_bus.rsp_valid = r_rsp_valid;
   assign io_bus.rsp_rdata = r_rsp_rdata;
   assign io_bus.rsp_err   = r_rsp_err;
   assign io_bus.busy      = (r_state == INIT);

endmodule
